// File: rtl/pp_trace_pkg.sv
// Shared types and width helpers for the instruction-trace capture buffer.
package pp_trace_pkg;

   localparam int DEF_DEPTH   = 64;
   localparam int DEF_PC_W    = 32;
   localparam int DEF_INSTR_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      TRIGGERED,
      DONE,
      READ
   } trace_state_t;

   typedef struct packed {
      logic [DEF_PC_W-1:0]    pc;
      logic [DEF_INSTR_W-1:0] instr;
   } trace_entry_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pp_trace_watch.sv
// PC watchpoint comparators; hit is the OR of all enabled channel matches.
module pp_trace_watch
   import pp_trace_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int N_WATCH = 2
) (
   input  logic [PC_W-1:0]         pc,
   input  logic [N_WATCH-1:0]      watch_en,
   input  logic [N_WATCH*PC_W-1:0] watch_pc,
   output logic                    hit
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_WATCH; i++) begin
         if (watch_en[i] && (pc == watch_pc[i*PC_W +: PC_W])) hit = 1'b1;
      end
   end

endmodule

// File: rtl/pp_trace_buffer.sv
// Circular (PC, instruction) trace capture with watchpoint/forced trigger,
// post-trigger fill, and chronological valid/ready readout.
//
// state     | meaning
// IDLE      | after reset, capture ignored until arm
// ARMED     | capturing, waiting for trigger
// TRIGGERED | capturing POST_TRIG more entries
// DONE      | capture frozen, waiting for rd_start
// READ      | streaming entries oldest to newest
module pp_trace_buffer
   import pp_trace_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int PC_W      = DEF_PC_W,
   parameter int INSTR_W   = DEF_INSTR_W,
   parameter int N_WATCH   = 2,
   parameter int POST_TRIG = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       cap_valid,
   input  logic [PC_W-1:0]            cap_pc,
   input  logic [INSTR_W-1:0]         cap_instr,
   input  logic [N_WATCH-1:0]         watch_en,
   input  logic [N_WATCH*PC_W-1:0]    watch_pc,
   input  logic                       trig_force,
   input  logic                       rd_start,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [PC_W-1:0]            rd_pc,
   output logic [INSTR_W-1:0]         rd_instr,
   output logic                       rd_last,
   output logic                       armed,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH)-1:0]   trig_pos
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int EW = PC_W + INSTR_W;

   trace_state_t  state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_idx;
   logic [CW-1:0] post_cnt;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] trig_pos_full;
   logic [CW-1:0] last_idx;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] rd_word;
   logic          hit;
   logic          wr_en;
   logic          idx_last;

   pp_trace_watch #(
      .PC_W    (PC_W),
      .N_WATCH (N_WATCH)
   ) u_watch (
      .pc       (cap_pc),
      .watch_en (watch_en),
      .watch_pc (watch_pc),
      .hit      (hit)
   );

   assign wr_en         = cap_valid && !arm && ((state == ARMED) || (state == TRIGGERED));
   assign cnt_next      = (count == CW'(DEPTH)) ? count : count + CW'(1);
   // Trigger position is derived from the count including the final write.
   assign trig_pos_full = cnt_next - CW'(1) - CW'(POST_TRIG);
   assign last_idx      = count - CW'(1);
   assign idx_last      = ({1'b0, rd_idx} == last_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_idx   <= '0;
         count    <= '0;
         post_cnt <= '0;
         trig_pos <= '0;
      end else if (arm) begin
         state    <= ARMED;
         wr_ptr   <= '0;
         count    <= '0;
         post_cnt <= '0;
      end else begin
         case (state)
            ARMED: begin
               if (cap_valid) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  count  <= cnt_next;
                  if (hit || trig_force) begin
                     if (POST_TRIG == 0) begin
                        state    <= DONE;
                        trig_pos <= trig_pos_full[AW-1:0];
                     end else begin
                        state    <= TRIGGERED;
                        post_cnt <= CW'(POST_TRIG);
                     end
                  end
               end
            end
            TRIGGERED: begin
               if (cap_valid) begin
                  wr_ptr   <= wr_ptr + 1'b1;
                  count    <= cnt_next;
                  post_cnt <= post_cnt - CW'(1);
                  if (post_cnt == CW'(1)) begin
                     state    <= DONE;
                     trig_pos <= trig_pos_full[AW-1:0];
                  end
               end
            end
            DONE: begin
               if (rd_start) begin
                  state  <= READ;
                  // A full buffer has wrapped, so the oldest entry sits at wr_ptr.
                  rd_ptr <= (count == CW'(DEPTH)) ? wr_ptr : '0;
                  rd_idx <= '0;
               end
            end
            READ: begin
               if (rd_ready) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  rd_idx <= rd_idx + 1'b1;
                  if (idx_last) state <= DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {cap_pc, cap_instr};
   end

   assign rd_word  = mem[rd_ptr];
   assign rd_valid = (state == READ);
   assign rd_last  = rd_valid && idx_last;
   // Gate the RAM read so outputs are zero outside READ, RAM contents being uninitialised.
   assign rd_pc    = rd_valid ? rd_word[EW-1 -: PC_W] : '0;
   assign rd_instr = rd_valid ? rd_word[INSTR_W-1:0] : '0;
   assign armed    = (state == ARMED) || (state == TRIGGERED);
   assign done     = (state == DONE);

endmodule

// File: tb/tb_pp_trace_buffer.sv
// Directed bench for pp_trace_buffer (DEPTH=8, POST_TRIG=3 plus a POST_TRIG=0 build).
module tb_pp_trace_buffer;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arm = 1'b0, arm0 = 1'b0;
   logic        cap_valid = 1'b0, cap_valid0 = 1'b0;
   logic [31:0] cap_pc = '0;
   logic [31:0] cap_instr = '0;
   logic [1:0]  watch_en = '0;
   logic [63:0] watch_pc = '0;
   logic        trig_force = 1'b0, trig_force0 = 1'b0;
   logic        rd_start = 1'b0, rd_ready = 1'b0;
   logic        rd_start0 = 1'b0, rd_ready0 = 1'b0;

   logic        rd_valid, rd_last, armed, done;
   logic [31:0] rd_pc, rd_instr;
   logic [3:0]  count;
   logic [2:0]  trig_pos;

   logic        rd_valid0, rd_last0, armed0, done0;
   logic [31:0] rd_pc0, rd_instr0;
   logic [3:0]  count0;
   logic [2:0]  trig_pos0;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   pp_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .N_WATCH(2), .POST_TRIG(3)) u_dut (
      .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid), .cap_pc(cap_pc),
      .cap_instr(cap_instr), .watch_en(watch_en), .watch_pc(watch_pc),
      .trig_force(trig_force), .rd_start(rd_start), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_last(rd_last),
      .armed(armed), .done(done), .count(count), .trig_pos(trig_pos)
   );

   pp_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .N_WATCH(2), .POST_TRIG(0)) u_dut0 (
      .clk(clk), .rst(rst), .arm(arm0), .cap_valid(cap_valid0), .cap_pc(cap_pc),
      .cap_instr(cap_instr), .watch_en(2'b00), .watch_pc(watch_pc),
      .trig_force(trig_force0), .rd_start(rd_start0), .rd_ready(rd_ready0),
      .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_last(rd_last0),
      .armed(armed0), .done(done0), .count(count0), .trig_pos(trig_pos0)
   );

   function automatic logic [31:0] pc_of(input int k);
      return 32'h0040_0000 + 32'(4 * k);
   endfunction

   function automatic logic [31:0] instr_of(input int k);
      return 32'hA500_0000 + 32'(k);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic capture(input int k, input logic valid);
      cap_valid = valid;
      cap_pc    = pc_of(k);
      cap_instr = instr_of(k);
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic readout(input int k0, input int n, input bit stall);
      int idx = 0;
      int stall_left = stall ? 3 : 0;
      int cyc = 0;
      for (int i = 0; i < n; i++) exp_q.push_back({pc_of(k0 + i), instr_of(k0 + i), (i == n - 1)});
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("rd_valid_start", rd_valid, 1);
      while (idx < n && cyc < 100) begin
         if (stall && idx == 2 && stall_left > 0) begin
            rd_ready = 1'b0;
            chk("stall_valid", rd_valid, 1);
            chk("stall_pc", rd_pc, pc_of(k0 + 2));
            stall_left--;
         end else begin
            rd_ready = 1'b1;
            idx++;
         end
         tick();
         cyc++;
      end
      rd_ready = 1'b0;
      if (idx < n) begin
         errors++;
         $display("FAIL readout_timeout actual=%0d required=%0d", idx, n);
      end
      chk("rd_back_done", done, 1);
      chk("rd_valid_after", rd_valid, 0);
      chk("exp_q_drained", 64'(exp_q.size()), 0);
   endtask

   // Monitor: any handshake consumes the next expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_extra actual_pc=%0h required=none", rd_pc);
            end else begin
               e = exp_q.pop_front();
               chk("rd_pc", rd_pc, e.pc);
               chk("rd_instr", rd_instr, e.instr);
               chk("rd_last", rd_last, e.last);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      // Reset state
      #1;
      chk("rst_count", count, 0);
      chk("rst_armed", armed, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      tick();

      // IDLE ignores captures
      watch_en = 2'b01;
      watch_pc[31:0] = pc_of(1);
      capture(0, 1'b1);
      capture(1, 1'b1);
      chk("idle_count", count, 0);
      chk("idle_armed", armed, 0);

      // Wraparound trigger at k=8
      watch_pc[31:0] = pc_of(8);
      pulse_arm();
      chk("arm_armed", armed, 1);
      for (int k = 0; k < 20; k++) begin
         capture(k, 1'b1);
         if (k == 10) chk("wrap_not_done_k10", done, 0);
         if (k == 11) begin
            chk("wrap_done_k11", done, 1);
            chk("wrap_count", count, 8);
            chk("wrap_trig_pos", trig_pos, 4);
         end
      end
      chk("wrap_count_hold", count, 8);
      chk("wrap_armed", armed, 0);
      readout(4, 8, 1'b0);

      // Early trigger at k=1
      watch_pc[31:0] = pc_of(1);
      pulse_arm();
      for (int k = 0; k < 7; k++) begin
         capture(k, 1'b1);
         if (k == 3) chk("early_not_done", done, 0);
      end
      chk("early_done", done, 1);
      chk("early_count", count, 5);
      chk("early_trig_pos", trig_pos, 1);
      readout(0, 5, 1'b0);

      // Channel select and cap_valid qualification
      watch_en = 2'b10;
      watch_pc[31:0]  = pc_of(3);
      watch_pc[63:32] = pc_of(6);
      pulse_arm();
      for (int k = 0; k < 6; k++) capture(k, 1'b1);
      capture(6, 1'b0);
      chk("chan_still_armed", armed, 1);
      chk("chan_no_trig_count", count, 6);
      for (int k = 6; k < 10; k++) begin
         capture(k, 1'b1);
         if (k == 8) chk("chan_not_done_k8", done, 0);
      end
      chk("chan_done", done, 1);
      chk("chan_count", count, 8);
      chk("chan_trig_pos", trig_pos, 4);
      readout(2, 8, 1'b1);
      readout(2, 8, 1'b0);

      // arm aborts a readout
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      chk("abort_in_read", rd_valid, 1);
      pulse_arm();
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_count", count, 0);
      chk("abort_armed", armed, 1);

      // Asynchronous reset mid-TRIGGERED
      watch_en = 2'b01;
      watch_pc[31:0] = pc_of(1);
      capture(0, 1'b1);
      capture(1, 1'b1);
      capture(2, 1'b1);
      chk("pre_rst_armed", armed, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_armed", armed, 0);
      chk("arst_done", done, 0);
      chk("arst_count", count, 0);
      chk("arst_trig_pos", trig_pos, 0);
      chk("arst_rd_valid", rd_valid, 0);
      chk("arst_rd_pc", rd_pc, 0);
      @(negedge clk) rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) capture(k, 1'b1);
      chk("post_rst_count", count, 0);
      chk("post_rst_armed", armed, 0);

      // POST_TRIG=0 build, forced trigger
      arm0 = 1'b1;
      tick();
      arm0 = 1'b0;
      cap_pc = pc_of(9);
      trig_force0 = 1'b1;
      tick();
      trig_force0 = 1'b0;
      chk("pt0_force_no_valid", done0, 0);
      for (int k = 0; k < 3; k++) begin
         cap_valid0  = 1'b1;
         cap_pc      = pc_of(k);
         cap_instr   = instr_of(k);
         trig_force0 = (k == 2);
         tick();
         cap_valid0  = 1'b0;
         trig_force0 = 1'b0;
         if (k == 1) chk("pt0_not_done", done0, 0);
      end
      chk("pt0_done", done0, 1);
      chk("pt0_count", count0, 3);
      chk("pt0_trig_pos", trig_pos0, 2);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pp_trace_buffer.md
Name: pp_trace_buffer

Overview:
- Synthesizable, parametrised instruction-trace capture buffer for the pipelined core.
- Records (PC, instruction) pairs from the IF stage into a circular buffer with configurable depth.
- Stops capture on a PC watchpoint match (N channels) or a forced trigger, keeping a programmable number of post-trigger entries.
- Contents are then read out in chronological order over a valid/ready port; replaces cycle-by-cycle simulation-only status logging with on-chip capture.

Parameters:
- DEPTH, 64, number of trace entries; power of two, ≥4.
- PC_W, 32, width of the captured PC and watch addresses.
- INSTR_W, 32, width of the captured instruction.
- N_WATCH, 2, number of PC watchpoint channels, ≥1.
- POST_TRIG, 32, entries captured after the trigger entry; 0 ≤ POST_TRIG ≤ DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  pulse: clear buffer, enter ARMED.
- cap_valid  in  1  capture strobe (IF stage instruction valid).
- cap_pc  in  PC_W  PC to capture.
- cap_instr  in  INSTR_W  instruction to capture.
- watch_en  in  N_WATCH  per-channel watchpoint enable.
- watch_pc  in  N_WATCH*PC_W  watch addresses; channel i occupies bits [i*PC_W +: PC_W].
- trig_force  in  1  force trigger; qualified by cap_valid.
- rd_start  in  1  pulse: begin readout (honoured in DONE only).
- rd_ready  in  1  consumer ready.
- rd_valid  out  1  readout entry valid.
- rd_pc  out  PC_W  readout PC.
- rd_instr  out  INSTR_W  readout instruction.
- rd_last  out  1  current readout entry is the newest.
- armed  out  1  state is ARMED or TRIGGERED.
- done  out  1  state is DONE.
- count  out  clog2(DEPTH)+1  number of valid entries (saturates at DEPTH).
- trig_pos  out  clog2(DEPTH)  readout index of the trigger entry.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - wr_ptr, rd_ptr, count, post_cnt and trig_pos are cleared.
  - All outputs are 0.
  - Buffer RAM is not cleared.
- States: IDLE, ARMED, TRIGGERED, DONE, READ.
- arm, from any state, has highest priority:
  - Next state is ARMED; wr_ptr=0, count=0.
  - Aborts any capture or readout in progress; rd_valid drops the next cycle.
- IDLE/DONE/READ: cap_valid is ignored and no writes occur.
- ARMED, each cap_valid:
  - Write {cap_pc, cap_instr} at wr_ptr; wr_ptr increments modulo DEPTH; count increments, saturating at DEPTH.
  - Trigger when any i has watch_en[i] && cap_pc==watch_pc[i], or trig_force. The matching entry is written and is the trigger entry.
  - On trigger with POST_TRIG>0: go to TRIGGERED with post_cnt=POST_TRIG.
  - On trigger with POST_TRIG==0: go directly to DONE.
  - A watch match or trig_force without cap_valid has no effect.
- TRIGGERED, each cap_valid:
  - Write as in ARMED; post_cnt decrements.
  - Go to DONE when the write occurs with post_cnt==1.
  - Further watch matches are ignored.
- On entry to DONE: trig_pos = count-1-POST_TRIG, using the final count.
- DONE + rd_start (and no arm): go to READ.
  - rd_ptr = wr_ptr if count==DEPTH, else 0.
  - A readout index counter is cleared.
- READ:
  - rd_valid=1; rd_pc/rd_instr are a combinational read of the entry at rd_ptr.
  - rd_last=1 when the readout index == count-1.
  - On rd_valid&&rd_ready: rd_ptr increments modulo DEPTH and the index increments.
  - A handshake with rd_last returns the state to DONE, so the buffer can be re-read.
  - With rd_ready low, all rd_* outputs are held stable.
- count==0 in DONE cannot occur; a trigger always writes an entry.
- done and armed are registered state decodes, with no extra latency.

Decomposition:
- Package pp_trace_pkg holds:
  - the state enum trace_state_t (IDLE, ARMED, TRIGGERED, DONE, READ);
  - the entry struct trace_entry_t {pc, instr}, with widths taken from the PC_W/INSTR_W defaults;
  - localparams for pointer widths.
- Sub-module pp_trace_watch: N_WATCH comparators producing a one-bit hit; purely combinational.
- The RAM is inferred inside pp_trace_buffer.

Test Plan (DEPTH=8, POST_TRIG=3, PC sequence k: 0x00400000+4k):
- Wraparound trigger: arm, watch_en=2'b01, watch_pc[0]=0x00400020, 20 contiguous captures.
  - Trigger at k=8; DONE after k=11; count=8, trig_pos=4.
  - Readout PCs are k=4..11, with rd_last on 0x0040002C.
- Early trigger: watch at k=1.
  - DONE after k=4; count=5, trig_pos=1.
  - Readout k=0..4.
- Channel/qualification: watch_en=2'b10, watch_pc[0]=k3, watch_pc[1]=k6.
  - cap_valid=0 in a cycle with PC=k6 → no trigger.
  - Later valid k6 triggers; channel 0's match at k3 is ignored.
- Backpressure: during readout, rd_ready=0 for 3 cycles at index 2.
  - rd_valid stays 1 and rd_pc is stable at the index-2 entry.
  - Resume completes all 8 entries exactly once; rd_start again re-reads the identical sequence.
- Abort and reset:
  - arm during READ → rd_valid=0 next cycle, count=0, armed=1.
  - rst asserted mid-TRIGGERED, asynchronously between clock edges → all outputs 0 immediately.
  - After rst, the state is IDLE and captures are ignored until arm.
- POST_TRIG=0 build: trig_force with cap_valid at k=2.
  - DONE the next cycle; count=3, trig_pos=2.
